// File: rtl/macguffin_pkg.sv
// Shared widths, packer FSM states and the PKCS#7 padding helper for the
// 8-byte block packer.
package macguffin_pkg;

  localparam int BLOCK_W         = 64;
  localparam int BYTE_W          = 8;
  localparam int BYTES_PER_BLOCK = 8;

  typedef enum logic {
    FILL    = 1'b0,
    PAD_BLK = 1'b1
  } packer_state_t;

  typedef struct packed {
    logic [BLOCK_W-1:0] mask;
    logic [BLOCK_W-1:0] value;
  } pad_t;

  localparam logic [BLOCK_W-1:0] FULL_PAD_BLOCK = {BYTES_PER_BLOCK{8'h08}};

  // last_idx is the byte position of the final message byte; every byte after
  // it is padding of value (7 - last_idx). last_idx == 7 yields an empty mask.
  function automatic pad_t pkcs7_pad(input logic [2:0] last_idx);
    pad_t             p;
    logic [BYTE_W-1:0] pad_byte;
    pad_byte = BYTE_W'(BYTES_PER_BLOCK - 1 - int'(last_idx));
    p.mask   = '0;
    p.value  = '0;
    for (int i = 0; i < BYTES_PER_BLOCK; i++) begin
      if (i > int'(last_idx)) begin
        p.mask[BLOCK_W-1-i*BYTE_W -: BYTE_W]  = '1;
        p.value[BLOCK_W-1-i*BYTE_W -: BYTE_W] = pad_byte;
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/axis_block_packer.sv
// Packs an AXI-Stream byte stream into big-endian 64-bit blocks with PKCS#7
// padding on the final block, through a single output holding register.
module axis_block_packer
  import macguffin_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [BYTE_W-1:0]  s_axis_tdata,
  input  logic               s_axis_tvalid,
  input  logic               s_axis_tlast,
  output logic               s_axis_tready,
  output logic [BLOCK_W-1:0] m_axis_tdata,
  output logic               m_axis_tvalid,
  output logic               m_axis_tlast,
  input  logic               m_axis_tready
);

  packer_state_t      r_state;
  logic [2:0]         r_cnt;
  logic [BLOCK_W-1:0] r_acc;
  logic [BLOCK_W-1:0] r_m_tdata;
  logic               r_m_tvalid;
  logic               r_m_tlast;

  packer_state_t      w_state_next;
  logic [2:0]         w_cnt_next;
  logic [BLOCK_W-1:0] w_acc_next;
  logic [BLOCK_W-1:0] w_acc_ins;
  logic               w_out_free;
  logic               w_s_fire;
  logic               w_load;
  logic [BLOCK_W-1:0] w_load_data;
  logic               w_load_last;
  pad_t               w_pad;

  assign w_out_free    = !r_m_tvalid || m_axis_tready;
  assign s_axis_tready = (r_state == FILL) && w_out_free;
  assign w_s_fire      = s_axis_tvalid && s_axis_tready;
  assign w_pad         = pkcs7_pad(r_cnt);

  assign m_axis_tdata  = r_m_tdata;
  assign m_axis_tvalid = r_m_tvalid;
  assign m_axis_tlast  = r_m_tlast;

  // Byte position p lives at bit 8*(7-p), i.e. {~p, 3'b000}.
  always_comb begin
    w_acc_ins = r_acc;
    w_acc_ins[{~r_cnt, 3'b000} +: BYTE_W] = s_axis_tdata;
  end

  // NOTE: every output gets a default first so no path leaves one unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_acc_next   = r_acc;
    w_load       = 1'b0;
    w_load_data  = r_m_tdata;
    w_load_last  = r_m_tlast;
    case (r_state)
      FILL: begin
        if (w_s_fire) begin
          w_acc_next = w_acc_ins;
          w_cnt_next = r_cnt + 3'd1;
          if (r_cnt == 3'd7 || s_axis_tlast) begin
            w_load      = 1'b1;
            w_cnt_next  = '0;
            // A full block has an empty pad mask, so one expression serves both.
            w_load_data = (w_acc_ins & ~w_pad.mask) | (w_pad.value & w_pad.mask);
            w_load_last = s_axis_tlast && (r_cnt != 3'd7);
            if (s_axis_tlast && r_cnt == 3'd7) w_state_next = PAD_BLK;
          end
        end
      end
      PAD_BLK: begin
        if (w_out_free) begin
          w_load       = 1'b1;
          w_load_data  = FULL_PAD_BLOCK;
          w_load_last  = 1'b1;
          w_state_next = FILL;
        end
      end
      default: w_state_next = FILL;
    endcase
  end

  // NOTE: registers use non-blocking assignments so every flop samples the
  // pre-edge values computed above, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst) r_state <= FILL;
    else      r_state <= w_state_next;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt      <= '0;
      r_acc      <= '0;
      r_m_tdata  <= '0;
      r_m_tvalid <= 1'b0;
      r_m_tlast  <= 1'b0;
    end else begin
      r_cnt <= w_cnt_next;
      r_acc <= w_acc_next;
      if (w_load) begin
        r_m_tvalid <= 1'b1;
        r_m_tdata  <= w_load_data;
        r_m_tlast  <= w_load_last;
      end else if (m_axis_tready) begin
        r_m_tvalid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_axis_block_packer.sv
// Scoreboard bench for axis_block_packer: directed vectors plus a randomized
// soak checked against a bytes-to-PKCS#7-blocks reference model.
module tb_axis_block_packer;
  import macguffin_pkg::*;

  typedef struct packed {
    logic [63:0] data;
    logic        last;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  s_axis_tdata;
  logic        s_axis_tvalid;
  logic        s_axis_tlast;
  logic        s_axis_tready;
  logic [63:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tlast;
  logic        m_axis_tready;

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   nready_cnt = 0;
  bit   use_model  = 1'b0;
  bit   rnd_ready  = 1'b0;

  exp_t       exp_q[$];
  logic [7:0] msg_q[$];

  logic        prev_stall = 1'b0;
  logic [63:0] prev_data;
  logic        prev_last;

  axis_block_packer dut (
    .clk          (clk),
    .rst          (rst),
    .s_axis_tdata (s_axis_tdata),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tlast (s_axis_tlast),
    .s_axis_tready(s_axis_tready),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tlast (m_axis_tlast),
    .m_axis_tready(m_axis_tready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%h want=%h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  task automatic push_exp(input logic [63:0] d, input logic l);
    exp_t e;
    e.data = d;
    e.last = l;
    exp_q.push_back(e);
  endtask

  // Reference model: collect message bytes, pad the whole message on tlast.
  task automatic model_accept(input logic [7:0] d, input logic l);
    int          pl;
    int          nb;
    logic [63:0] blk;
    msg_q.push_back(d);
    if (!l) begin
      if (msg_q.size() == 8) begin
        blk = '0;
        for (int i = 0; i < 8; i++) blk = {blk[55:0], msg_q.pop_front()};
        push_exp(blk, 1'b0);
      end
    end else begin
      pl = 8 - (msg_q.size() % 8);
      for (int i = 0; i < pl; i++) msg_q.push_back(8'(pl));
      nb = msg_q.size() / 8;
      for (int b = 0; b < nb; b++) begin
        blk = '0;
        for (int i = 0; i < 8; i++) blk = {blk[55:0], msg_q.pop_front()};
        push_exp(blk, b == nb - 1);
      end
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_valid", 64'(m_axis_tvalid), 64'd1);
        check("hold_data", m_axis_tdata, prev_data);
        check("hold_last", 64'(m_axis_tlast), 64'(prev_last));
      end
      if (!s_axis_tready) nready_cnt++;
      if (s_axis_tvalid && s_axis_tready && use_model)
        model_accept(s_axis_tdata, s_axis_tlast);
      if (m_axis_tvalid && m_axis_tready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_blk", m_axis_tdata, 64'hxxxx_xxxx_xxxx_xxxx);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("blk_data", m_axis_tdata, e.data);
          check("blk_last", 64'(m_axis_tlast), 64'(e.last));
        end
      end
      prev_stall = m_axis_tvalid && !m_axis_tready;
      prev_data  = m_axis_tdata;
      prev_last  = m_axis_tlast;
    end
  end

  // Randomized downstream ready, active only during the soak.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rnd_ready) m_axis_tready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic send_byte(input logic [7:0] d, input logic l);
    int   n;
    logic taken;
    n     = 0;
    taken = 1'b0;
    s_axis_tdata  = d;
    s_axis_tlast  = l;
    s_axis_tvalid = 1'b1;
    while (!taken && n < 1000) begin
      @(negedge clk);
      taken = s_axis_tready;
      n++;
      @(posedge clk);
      #1;
    end
    s_axis_tvalid = 1'b0;
    if (!taken) check("send_timeout", 64'd0, 64'd1);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || m_axis_tvalid) && n < 500) begin
      idle(1);
      n++;
    end
    check(tag, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    int remaining;
    int len;

    rst           = 1'b0;
    s_axis_tdata  = '0;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    m_axis_tready = 1'b1;
    idle(3);
    check("rst_m_tvalid", 64'(m_axis_tvalid), 64'd0);
    check("rst_m_tdata", m_axis_tdata, 64'd0);
    check("rst_m_tlast", 64'(m_axis_tlast), 64'd0);
    check("rst_s_tready", 64'(s_axis_tready), 64'd1);
    rst = 1'b1;
    idle(2);

    // Two full blocks plus a whole pad block, one intake stall cycle.
    push_exp(64'h0001020304050607, 1'b0);
    push_exp(64'h08090A0B0C0D0E0F, 1'b0);
    push_exp(64'h0808080808080808, 1'b1);
    nready_cnt = 0;
    for (int i = 0; i < 16; i++) send_byte(8'(i), i == 15);
    idle(3);
    check("pad_stall_cycles", 64'(nready_cnt), 64'd1);
    drain("drain_16");

    // Short message, block visible one cycle after the last byte.
    push_exp(64'hAABBCC0505050505, 1'b1);
    send_byte(8'hAA, 1'b0);
    send_byte(8'hBB, 1'b0);
    check("short_no_early", 64'(m_axis_tvalid), 64'd0);
    send_byte(8'hCC, 1'b1);
    check("short_latency_valid", 64'(m_axis_tvalid), 64'd1);
    check("short_latency_data", m_axis_tdata, 64'hAABBCC0505050505);
    drain("drain_short");

    // Back-to-back short messages with no gap.
    push_exp(64'h1107070707070707, 1'b1);
    push_exp(64'h2122232425262701, 1'b1);
    nready_cnt = 0;
    c0 = cyc;
    send_byte(8'h11, 1'b1);
    for (int i = 0; i < 7; i++) send_byte(8'(8'h21 + i), i == 6);
    check("b2b_cycles", 64'(cyc - c0), 64'd8);
    check("b2b_no_stall", 64'(nready_cnt), 64'd0);
    drain("drain_b2b");

    // Downstream backpressure for 20 cycles with a block pending.
    push_exp(64'h4041424344454647, 1'b0);
    push_exp(64'h48494A4B4C4D4E4F, 1'b0);
    push_exp(64'h0808080808080808, 1'b1);
    m_axis_tready = 1'b0;
    for (int i = 0; i < 8; i++) send_byte(8'(8'h40 + i), 1'b0);
    s_axis_tdata  = 8'h48;
    s_axis_tlast  = 1'b0;
    s_axis_tvalid = 1'b1;
    nready_cnt = 0;
    repeat (20) begin
      @(negedge clk);
      @(posedge clk);
      #1;
    end
    check("bp_s_tready_low", 64'(nready_cnt), 64'd20);
    check("bp_m_tdata", m_axis_tdata, 64'h4041424344454647);
    m_axis_tready = 1'b1;
    @(negedge clk);
    check("bp_resume_tready", 64'(s_axis_tready), 64'd1);
    @(posedge clk);
    #1;
    s_axis_tvalid = 1'b0;
    for (int i = 1; i < 8; i++) send_byte(8'(8'h48 + i), i == 7);
    drain("drain_bp");

    // Reset mid-message discards the partial block.
    for (int i = 0; i < 5; i++) send_byte(8'(8'h50 + i), 1'b0);
    rst = 1'b0;
    idle(1);
    check("midrst_s_tready", 64'(s_axis_tready), 64'd1);
    rst = 1'b1;
    idle(4);
    check("midrst_m_tvalid", 64'(m_axis_tvalid), 64'd0);
    push_exp(64'h3031323334353637, 1'b0);
    push_exp(64'h0808080808080808, 1'b1);
    for (int i = 0; i < 8; i++) send_byte(8'(8'h30 + i), i == 7);
    drain("drain_midrst");

    // Randomized soak against the reference model.
    use_model = 1'b1;
    rnd_ready = 1'b1;
    remaining = 10000;
    while (remaining > 0) begin
      len = $urandom_range(1, 20);
      if (len > remaining) len = remaining;
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 3) == 0) idle(1);
        send_byte(8'($urandom), i == len - 1);
      end
      remaining -= len;
    end
    rnd_ready = 1'b0;
    idle(1);
    m_axis_tready = 1'b1;
    drain("drain_soak");
    check("soak_model_residue", 64'(msg_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
